// File: rtl/mult_8x8_seq_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier.
// The operand source and result sink sit on the master side.
interface mult_8x8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mult_8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 array multiplier,
// four partial products shift-accumulated into a 16-bit result.
module mult_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  always_comb begin
    o_p = '0;
    for (int i = 0; i < 4; i++) begin
      if (i_b[i]) o_p = o_p + (8'(i_a) << i);
    end
  end
endmodule

module mult_8x8_seq (
  input  logic           clk,
  input  logic           rst,
  mult_8x8_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;
  logic [7:0]  r_ra;
  logic [7:0]  r_rb;
  logic [15:0] r_acc;
  logic [15:0] r_p;
  logic [3:0]  w_op_a;
  logic [3:0]  w_op_b;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_sh;
  logic [15:0] w_sum;
  logic        w_accept;

  assign w_accept = bus.in_valid && r_in_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = PP0;
      PP0:     w_next = PP1;
      PP1:     w_next = PP2;
      PP2:     w_next = PP3;
      PP3:     w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand select for the shared core: low/high nibbles per partial product
  always_comb begin
    w_op_a = r_ra[3:0];
    w_op_b = r_rb[3:0];
    case (r_state)
      PP1:     w_op_a = r_ra[7:4];
      PP2:     w_op_b = r_rb[7:4];
      PP3: begin
        w_op_a = r_ra[7:4];
        w_op_b = r_rb[7:4];
      end
      default: ;
    endcase
  end

  mult_4x4 u_core (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_p (w_pp)
  );

  always_comb begin
    w_pp_sh = 16'(w_pp);
    case (r_state)
      PP1, PP2: w_pp_sh = 16'(w_pp) << 4;
      PP3:      w_pp_sh = 16'(w_pp) << 8;
      default:  ;
    endcase
  end

  // Max final sum is 0xFE01, so dropping the carry out of bit 15 is safe
  assign w_sum = r_acc + w_pp_sh;

  // in_ready is registered so it never depends combinationally on inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra  <= '0;
      r_rb  <= '0;
      r_acc <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ra  <= bus.a;
            r_rb  <= bus.b;
            r_acc <= '0;
          end
        end
        PP0, PP1, PP2: r_acc <= w_sum;
        PP3: begin
          r_acc <= w_sum;
          r_p   <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.p         = r_p;
endmodule

// File: tb/tb_mult_8x8_seq.sv
// Bench for mult_8x8_seq: directed vectors with literal products plus a
// queue-based product model checked on every cycle a result is presented.
module tb_mult_8x8_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  mult_8x8_seq_if bus_if ();

  mult_8x8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a product is owed for every accepted operand pair, in order
  logic [15:0] q[$];
  logic        prev_ov;
  int          last_acc_edge;
  int          have_last;
  int          chk_spacing;
  int          xfers;
  int          accepts;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_ov   = 1'b0;
      have_last = 0;
    end else begin
      if (bus_if.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus_if.out_valid), 32'd0);
        end else begin
          chk("model_p", 32'(bus_if.p), 32'(q[0]));
          if (!prev_ov) chk("model_latency", 32'(cyc - last_acc_edge), 32'd4);
          if (bus_if.out_ready) begin
            void'(q.pop_front());
            xfers++;
          end
        end
      end
      prev_ov = bus_if.out_valid;
      if (bus_if.in_ready && bus_if.busy) chk("ready_while_busy", 32'd1, 32'd0);
      if (bus_if.in_valid && bus_if.in_ready) begin
        logic [15:0] e;
        e = 16'(bus_if.a) * 16'(bus_if.b);
        q.push_back(e);
        accepts++;
        if (chk_spacing != 0 && have_last != 0)
          chk("accept_spacing", 32'(cyc + 1 - last_acc_edge), 32'd6);
        last_acc_edge = cyc + 1;
        have_last     = 1;
      end
    end
  end

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input int stall,
                       input logic [15:0] req, input string nm);
    int n;
    n = 0;
    while (!bus_if.in_ready && n < 20) begin tick(); n++; end
    chk({nm, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    bus_if.a         = ia;
    bus_if.b         = ib;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = (stall == 0);
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.a        = ~ia;
    bus_if.b        = ~ib;
    n = 0;
    while (!bus_if.out_valid && n < 20) begin tick(); n++; end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_p"}, 32'(bus_if.p), 32'(req));
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_stall_p"}, 32'(bus_if.p), 32'(req));
      chk({nm, "_stall_ready"}, 32'(bus_if.in_ready), 32'd0);
      chk({nm, "_stall_valid"}, 32'(bus_if.out_valid), 32'd1);
      tick();
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    chk({nm, "_after_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({nm, "_after_ready"}, 32'(bus_if.in_ready), 32'd1);
    chk({nm, "_held_p"}, 32'(bus_if.p), 32'(req));
  endtask

  logic [7:0] ca[6];
  logic [7:0] cb[6];

  initial begin
    int n;
    int got;
    int a0;
    int x0;
    int sent;
    int g;
    int bad;
    logic acc;
    checks = 0; errors = 0; cyc = 0; xfers = 0; accepts = 0;
    chk_spacing = 0; have_last = 0; prev_ov = 1'b0; last_acc_edge = 0;
    ca = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'hAA};
    cb = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h80, 8'h55};
    rst = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
    bus_if.a = '0; bus_if.b = '0;

    tick(); tick();
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_p", 32'(bus_if.p), 32'd0);
    rst = 1'b0;
    chk("release_in_ready_low", 32'(bus_if.in_ready), 32'd0);
    tick();
    chk("release_in_ready_high", 32'(bus_if.in_ready), 32'd1);

    do_op(8'h0A, 8'h0C, 0, 16'h0078, "op_0a_0c");
    do_op(8'hFF, 8'hFF, 0, 16'hFE01, "op_ff_ff");
    do_op(8'h00, 8'hB7, 0, 16'h0000, "op_00_b7");
    do_op(8'h9C, 8'h35, 5, 16'h204C, "backpressure");

    // Operands held valid and changing every cycle while busy
    chk_spacing = 1; have_last = 0; a0 = accepts; got = 0;
    bus_if.a = 8'h5A; bus_if.b = 8'h3C; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      bus_if.a = 8'($urandom);
      bus_if.b = 8'($urandom);
      if (bus_if.out_valid && got == 0) begin
        chk("ignore_first_p", 32'(bus_if.p), 32'h1518);
        got = 1;
      end
    end
    bus_if.in_valid = 1'b0;
    n = 0;
    while (bus_if.busy && n < 20) begin tick(); n++; end
    chk("ignore_got_result", 32'(got), 32'd1);
    chk("ignore_accept_count", 32'(accepts - a0), 32'd3);
    chk_spacing = 0;
    bus_if.out_ready = 1'b0;

    // Reset asserted for one cycle while in PP2
    bus_if.a = 8'h77; bus_if.b = 8'h11; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    tick(); tick();
    chk("midrst_busy_before", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus_if.busy), 32'd0);
    chk("midrst_p", 32'(bus_if.p), 32'd0);
    chk("midrst_in_ready_low", 32'(bus_if.in_ready), 32'd0);
    tick();
    chk("midrst_in_ready_high", 32'(bus_if.in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_if.out_valid !== 1'b0 || bus_if.p !== 16'h0000) bad++;
      tick();
    end
    chk("midrst_no_result", 32'(bad), 32'd0);
    bus_if.out_ready = 1'b0;
    do_op(8'h12, 8'h34, 0, 16'h03A8, "after_midrst");

    // Corner pairs then random pairs, with random sink stalls
    x0 = xfers; sent = 0; g = 0;
    while (sent < 3000 && g < 60000) begin
      if (!bus_if.in_valid) begin
        if (sent < 6) begin
          bus_if.a = ca[sent];
          bus_if.b = cb[sent];
        end else begin
          bus_if.a = 8'($urandom);
          bus_if.b = 8'($urandom);
        end
        bus_if.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus_if.out_ready = ($urandom_range(0, 2) != 0);
      acc = bus_if.in_valid && bus_if.in_ready;
      tick();
      g++;
      if (acc) begin
        sent++;
        bus_if.in_valid = 1'b0;
      end
    end
    chk("random_sent", 32'(sent), 32'd3000);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    n = 0;
    while (bus_if.busy && n < 20) begin tick(); n++; end
    chk("random_transfers", 32'(xfers - x0), 32'd3000);
    chk("model_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
